// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared plotter encodings, screen geometry, command type and sequencer states
package vga_pkg;

    typedef enum logic [3:0] {
        ST_A      = 4'd0,
        ST_B      = 4'd1,
        ST_C      = 4'd2,
        ST_D      = 4'd3,
        ST_E      = 4'd4,
        ST_B_WAIT = 4'd8
    } plotter_state_t;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int BOX_SIZE = 4;

    // Largest top-left corner that still keeps the whole box on screen.
    localparam logic [8:0] CLIP_X_MAX = 9'(SCREEN_W - BOX_SIZE);
    localparam logic [7:0] CLIP_Y_MAX = 8'(SCREEN_H - BOX_SIZE);

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } box_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADX,
        S_GAP1,
        S_PLOT,
        S_RELEASE,
        S_WAIT
    } seq_state_t;

    function automatic box_cmd_t clip_cmd(input box_cmd_t c);
        box_cmd_t r;
        r = c;
        if (c.x > CLIP_X_MAX) r.x = CLIP_X_MAX;
        if (c.y > CLIP_Y_MAX) r.y = CLIP_Y_MAX;
        return r;
    endfunction

endpackage

// File: rtl/box_cmd_fifo.sv
// rtl/box_cmd_fifo.sv - synchronous command FIFO with occupancy count and registered ready
module box_cmd_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          iClock,
    input  logic          iResetn,
    input  logic          push,
    input  logic          pop,
    input  box_cmd_t      din,
    output box_cmd_t      dout,
    output logic [CW-1:0] count,
    output logic          ready
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    box_cmd_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_n;

    assign dout = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    // Storage write; entries need no reset since the pointers define validity.
    always_ff @(posedge iClock) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers, count and ready; ready is held low during reset and rises one cycle after.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            ready <= (count_n < FULL);
        end
    end

endmodule

// File: rtl/box_cmd_sequencer.sv
// rtl/box_cmd_sequencer.sv - queues box commands and replays them to the plotter; BOX_CLIP_EN clamps x/y at enqueue
module box_cmd_sequencer
    import vga_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     iClock,
    input  logic                     iResetn,
    input  logic                     iCmdValid,
    output logic                     oCmdReady,
    input  logic [8:0]               iCmdX,
    input  logic [7:0]               iCmdY,
    input  logic [2:0]               iCmdColour,
    input  logic [3:0]               iPlotterState,
    output logic [8:0]               oXY_Coord,
    output logic                     oLoadX,
    output logic                     oPlotBox,
    output logic [2:0]               oColour,
    output logic                     oBusy,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oTimeout
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t    state, state_n;
    box_cmd_t      raw_cmd, fifo_din, fifo_dout, cmd_q, cmd_n;
    logic          push, pop, fifo_ready, tmo_hit;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;

    assign raw_cmd = '{x: iCmdX, y: iCmdY, colour: iCmdColour};
`ifdef BOX_CLIP_EN
    assign fifo_din = clip_cmd(raw_cmd);
`else
    assign fifo_din = raw_cmd;
`endif

    assign push      = iCmdValid && fifo_ready;
    assign oCmdReady = fifo_ready;
    assign oBusy     = (state != S_IDLE) || (oCount != '0);
    assign cmd_n     = pop ? fifo_dout : cmd_q;

    box_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .iClock  (iClock),
        .iResetn (iResetn),
        .push    (push),
        .pop     (pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .count   (oCount),
        .ready   (fifo_ready)
    );

    // Next-state: pulse load-X, wait for plotter, pulse plot, wait for it to finish; waits are bounded.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (oCount != '0) begin
                    pop     = 1'b1;
                    state_n = S_LOADX;
                end
            end
            S_LOADX: begin
                if (hold_cnt == HOLD_LAST) state_n = S_GAP1;
            end
            S_GAP1: begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_n = S_IDLE;
                end else if (iPlotterState == ST_B_WAIT) begin
                    state_n = S_PLOT;
                end
            end
            S_PLOT: begin
                if (hold_cnt == HOLD_LAST) state_n = S_RELEASE;
            end
            S_RELEASE: begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_n = S_IDLE;
                end else if (iPlotterState != ST_C && iPlotterState != ST_B_WAIT) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_n = S_IDLE;
                end else if (iPlotterState == ST_A) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, counters, command register and registered plotter outputs decoded from the next state.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            tmo_cnt   <= '0;
            cmd_q     <= '0;
            oLoadX    <= 1'b0;
            oPlotBox  <= 1'b0;
            oXY_Coord <= '0;
            oColour   <= '0;
            oTimeout  <= 1'b0;
        end else begin
            state <= state_n;
            cmd_q <= cmd_n;

            if (state_n == state && (state == S_LOADX || state == S_PLOT))
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;

            if (pop)
                tmo_cnt <= '0;
            else if (state == S_GAP1 || state == S_RELEASE || state == S_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;

            oLoadX   <= (state_n == S_LOADX);
            oPlotBox <= (state_n == S_PLOT);

            case (state_n)
                S_LOADX, S_GAP1: oXY_Coord <= cmd_n.x;
                S_PLOT, S_RELEASE, S_WAIT: begin
                    oXY_Coord <= {1'b0, cmd_n.y};
                    oColour   <= cmd_n.colour;
                end
                default: ;
            endcase

            if (tmo_hit) oTimeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_box_cmd_sequencer.sv
// tb/tb_box_cmd_sequencer.sv - directed bench with a behavioural plotter for box_cmd_sequencer
module tb_box_cmd_sequencer;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_x;
    logic [7:0] cmd_y;
    logic [2:0] cmd_colour;
    logic [3:0] ps;
    logic [8:0] xy;
    logic       load_x, plot_box, busy, tmo;
    logic [2:0] colour;
    logic [2:0] count;

    always #5 clk = ~clk;

    box_cmd_sequencer dut (
        .iClock(clk), .iResetn(resetn), .iCmdValid(cmd_valid), .oCmdReady(cmd_ready),
        .iCmdX(cmd_x), .iCmdY(cmd_y), .iCmdColour(cmd_colour), .iPlotterState(ps),
        .oXY_Coord(xy), .oLoadX(load_x), .oPlotBox(plot_box), .oColour(colour),
        .oBusy(busy), .oCount(count), .oTimeout(tmo)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural plotter; force_en pins its state to force_val.
    logic       force_en = 1'b0;
    logic [3:0] force_val = ST_A;
    int         pcnt = 0;
    always @(posedge clk) begin
        if (!resetn) begin
            ps <= ST_A;
            pcnt <= 0;
        end else if (force_en) begin
            ps <= force_val;
        end else begin
            case (ps)
                ST_A:      if (load_x) ps <= ST_B;
                ST_B:      if (!load_x) ps <= ST_B_WAIT;
                ST_B_WAIT: if (plot_box) begin ps <= ST_C; pcnt <= 0; end
                ST_C:      if (!plot_box) begin
                               pcnt <= pcnt + 1;
                               if (pcnt == 2) ps <= ST_D;
                           end
                ST_D:      ps <= ST_E;
                default:   ps <= ST_A;
            endcase
        end
    end

    // Event monitor: load-X rising edges with their x and distance from the plotter's return to A.
    logic mon_en = 1'b0;
    int   mon_cyc, last_a, nlx, peak;
    int   lx_x [8];
    int   lx_gap [8];
    logic prev_lx;
    logic [3:0] prev_ps;
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_cyc = 0; last_a = -100; nlx = 0; peak = 0;
            prev_lx = 1'b0; prev_ps = ST_A;
        end else begin
            mon_cyc++;
            if (ps == ST_A && prev_ps != ST_A) last_a = mon_cyc;
            if (load_x && !prev_lx) begin
                if (nlx < 8) begin
                    lx_x[nlx] = int'(xy);
                    lx_gap[nlx] = mon_cyc - last_a;
                end
                nlx++;
            end
            if (int'(count) > peak) peak = int'(count);
            prev_lx = load_x;
            prev_ps = ps;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clip_x(input int x);
`ifdef BOX_CLIP_EN
        return (x > 316) ? 316 : x;
`else
        return x;
`endif
    endfunction

    function automatic int clip_y(input int y);
`ifdef BOX_CLIP_EN
        return (y > 236) ? 236 : y;
`else
        return y;
`endif
    endfunction

    // Called just after a falling edge; presents one command for one cycle.
    task automatic push(input int x, input int y, input int c, output bit acc);
        cmd_valid  = 1'b1;
        cmd_x      = 9'(x);
        cmd_y      = 8'(y);
        cmd_colour = 3'(c);
        acc        = cmd_ready;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    typedef struct {
        int x, y, c;
        int ex, ey;
    } vec_t;

    task automatic run_cmd(input vec_t v, input string tag, input int exp_tmo);
        bit acc;
        bit done = 0;
        int lx = 0, pb = 0, lx_xy = -1, pb_xy = -1, pb_col = -1, both = 0;
        push(v.x, v.y, v.c, acc);
        check({tag, "_accept"}, int'(acc), 1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (load_x) begin lx++; lx_xy = int'(xy); end
            if (plot_box) begin pb++; pb_xy = int'(xy); pb_col = int'(colour); end
            if (load_x && plot_box) both++;
            if (!busy && pb > 0) begin done = 1; break; end
            @(negedge clk);
        end
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_loadx_len"}, lx, 2);
        check({tag, "_loadx_xy"}, lx_xy, v.ex);
        check({tag, "_plot_len"}, pb, 2);
        check({tag, "_plot_xy"}, pb_xy, v.ey);
        check({tag, "_plot_colour"}, pb_col, v.c);
        check({tag, "_strobe_overlap"}, both, 0);
        check({tag, "_timeout"}, int'(tmo), exp_tmo);
    endtask

    vec_t vecs [6];
    bit   acc;
    bit   accs [6];
    int   nacc, wc;
    bit   seen;

    initial begin
        vecs[0] = '{x: 10,  y: 20,  c: 3, ex: clip_x(10),  ey: clip_y(20)};
        vecs[1] = '{x: 0,   y: 0,   c: 0, ex: clip_x(0),   ey: clip_y(0)};
        vecs[2] = '{x: 319, y: 239, c: 7, ex: clip_x(319), ey: clip_y(239)};
        vecs[3] = '{x: 316, y: 236, c: 5, ex: clip_x(316), ey: clip_y(236)};
        vecs[4] = '{x: 317, y: 237, c: 1, ex: clip_x(317), ey: clip_y(237)};
        vecs[5] = '{x: 100, y: 200, c: 6, ex: clip_x(100), ey: clip_y(200)};

        cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_colour = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_loadx", int'(load_x), 0);
        check("rst_plot", int'(plot_box), 0);
        check("rst_xy", int'(xy), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        check("rst_timeout", int'(tmo), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(cmd_ready), 1);

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i), 0);
            @(negedge clk);
        end

        // Back-to-back: three pushes on consecutive cycles.
        mon_en = 1'b1;
        @(negedge clk);
        push(10, 20, 1, acc);
        push(50, 60, 2, acc);
        push(90, 100, 4, acc);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy && nlx >= 3) begin seen = 1; break; end
            @(negedge clk);
        end
        check("b2b_done", int'(seen), 1);
        check("b2b_peak_count", peak, 2);
        check("b2b_starts", nlx, 3);
        check("b2b_order0", lx_x[0], 10);
        check("b2b_order1", lx_x[1], 50);
        check("b2b_order2", lx_x[2], 90);
        check("b2b_gap1", lx_gap[1], 2);
        check("b2b_gap2", lx_gap[2], 2);
        mon_en = 1'b0;
        @(negedge clk);

        // Backpressure: plotter stuck in B while six pushes are offered.
        force_val = ST_B; force_en = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) push(20 * i + 1, i, i, accs[i]);
        nacc = 0;
        for (int i = 0; i < 6; i++) nacc += int'(accs[i]);
        check("bp_accepted", nacc, 5);
        check("bp_last_refused", int'(accs[5]), 0);
        check("bp_count_full", int'(count), 4);
        check("bp_ready_low", int'(cmd_ready), 0);
        force_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!busy) begin seen = 1; break; end
            @(negedge clk);
        end
        check("bp_drained", int'(seen), 1);
        check("bp_executed", nlx, 5);
        for (int i = 0; i < 5; i++) check($sformatf("bp_order%0d", i), lx_x[i], 20 * i + 1);
        check("bp_timeout", int'(tmo), 0);
        mon_en = 1'b0;
        @(negedge clk);

        // Timeout: plotter never leaves A after load-X.
        force_val = ST_A; force_en = 1'b1;
        push(300, 200, 2, acc);
        for (int i = 0; i < 10 && !load_x; i++) @(negedge clk);
        check("tmo_loadx_seen", int'(load_x), 1);
        for (int i = 0; i < 10 && load_x; i++) @(negedge clk);
        wc = 0;
        for (int i = 0; i < 200 && !tmo; i++) begin
            wc++;
            @(negedge clk);
        end
        check("tmo_flag", int'(tmo), 1);
        check("tmo_wait_cycles", wc, 64);
        check("tmo_idle", int'(busy), 0);
        check("tmo_strobes", int'(load_x) + int'(plot_box), 0);
        check("tmo_xy_hold", int'(xy), 300);
        force_en = 1'b0;
        @(negedge clk);
        run_cmd(vecs[0], "after_tmo", 1);
        @(negedge clk);

        // Reset during the plot pulse.
        push(40, 44, 5, acc);
        push(41, 45, 6, acc);
        for (int i = 0; i < 50 && !plot_box; i++) @(negedge clk);
        check("rmid_plot_seen", int'(plot_box), 1);
        resetn = 1'b0;
        @(negedge clk);
        check("rmid_plot", int'(plot_box), 0);
        check("rmid_loadx", int'(load_x), 0);
        check("rmid_count", int'(count), 0);
        check("rmid_timeout", int'(tmo), 0);
        check("rmid_busy", int'(busy), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("rmid_ready", int'(cmd_ready), 1);
        run_cmd(vecs[5], "after_reset", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
